// File: rtl/shadow_register_restorer.sv
// shadow_register_restorer
//   Reloads the shadow register file from the machine stack frame on an
//   interrupt return. Register i is read from restore_base + i*BYTES in
//   ascending order, one D$ load at a time. When the last word is written
//   back, the unwound stack pointer is reported for one cycle.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   restore_req_i/base_i      start pulse and frame base address
//   busy_o, done_o            restore in progress / one-cycle completion
//   restored_sp_o             base + NUM_SHADOW_SAVES*BYTES, valid with done_o
//   align_err_o               one-cycle pulse when the base was misaligned
//   shadow_reg_*              shadow register file write port
//   ld_*                      D$ load port (req/gnt, tag cycle, rvalid/rdata)

// Flags a start request that arrives while a restore is already running.
module shadow_register_restorer_chk (
  input logic clk,
  input logic rst_n,
  input logic busy,
  input logic restore_req
);

  a_req_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(busy && restore_req))
    else $warning("restore_req ignored while a restore is in progress");

endmodule

module shadow_register_restorer #(
  parameter int ADDR_WIDTH       = 6,
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_SHADOW_SAVES = 16,
  parameter int INDEX_WIDTH      = 12,
  parameter int TAG_WIDTH        = 22
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   restore_req_i,
  input  logic [DATA_WIDTH-1:0]  restore_base_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  restored_sp_o,
  output logic                   align_err_o,
  output logic                   shadow_reg_we_o,
  output logic [ADDR_WIDTH-1:0]  shadow_reg_waddr_o,
  output logic [DATA_WIDTH-1:0]  shadow_reg_wdata_o,
  output logic                   ld_req_o,
  input  logic                   ld_gnt_i,
  output logic [INDEX_WIDTH-1:0] ld_index_o,
  output logic [TAG_WIDTH-1:0]   ld_tag_o,
  output logic                   ld_tag_valid_o,
  output logic [1:0]             ld_size_o,
  input  logic                   ld_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  ld_rdata_i
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PA_W  = INDEX_WIDTH + TAG_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_SHADOW_SAVES - 1);
  localparam logic [DATA_WIDTH-1:0] STRIDE   = DATA_WIDTH'(BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_TAG  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e                  state_r;
  state_e                  state_s;
  logic [ADDR_WIDTH-1:0]   idx_r;
  logic [DATA_WIDTH-1:0]   addr_r;
  logic                    align_err_r;
  logic                    aligned_s;
  logic                    start_s;
  logic                    misalign_s;
  logic                    load_done_s;
  logic                    last_s;
  logic [PA_W-1:0]         pa_s;

  assign aligned_s   = (restore_base_i[OFF_W-1:0] == {OFF_W{1'b0}});
  assign start_s     = (state_r == S_IDLE) && restore_req_i && aligned_s;
  assign misalign_s  = (state_r == S_IDLE) && restore_req_i && !aligned_s;
  // A response is accepted in the tag cycle as well as in WAIT; anywhere
  // else (IDLE, REQ, DONE) a stray rvalid is dropped.
  assign load_done_s = ((state_r == S_TAG) || (state_r == S_WAIT)) && ld_rvalid_i;
  assign last_s      = (idx_r == LAST_IDX);
  // Physical address is the stack address zero-extended (or truncated) to index+tag.
  assign pa_s        = PA_W'(addr_r);
  assign align_err_o = align_err_r;
  assign ld_size_o   = 2'(OFF_W);

  // State, frame pointer and register index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= S_IDLE;
      idx_r       <= {ADDR_WIDTH{1'b0}};
      addr_r      <= {DATA_WIDTH{1'b0}};
      align_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      align_err_r <= misalign_s;
      if (start_s) begin
        addr_r <= restore_base_i;
        idx_r  <= {ADDR_WIDTH{1'b0}};
      end else if (load_done_s) begin
        // After the last word addr_r already equals the unwound stack pointer.
        addr_r <= addr_r + STRIDE;
        idx_r  <= idx_r + ADDR_WIDTH'(1);
      end
    end
  end

  // Next-state and load-port / write-port outputs.
  always_comb begin
    state_s            = state_r;
    busy_o             = 1'b0;
    done_o             = 1'b0;
    restored_sp_o      = {DATA_WIDTH{1'b0}};
    ld_req_o           = 1'b0;
    ld_index_o         = {INDEX_WIDTH{1'b0}};
    ld_tag_o           = {TAG_WIDTH{1'b0}};
    ld_tag_valid_o     = 1'b0;
    shadow_reg_we_o    = 1'b0;
    shadow_reg_waddr_o = {ADDR_WIDTH{1'b0}};
    shadow_reg_wdata_o = {DATA_WIDTH{1'b0}};

    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        busy_o     = 1'b1;
        ld_req_o   = 1'b1;
        ld_index_o = pa_s[INDEX_WIDTH-1:0];
        ld_tag_o   = pa_s[PA_W-1:INDEX_WIDTH];
        if (ld_gnt_i) begin
          state_s = S_TAG;
        end else begin
          state_s = S_REQ;
        end
      end
      S_TAG: begin
        busy_o         = 1'b1;
        ld_tag_valid_o = 1'b1;
        ld_tag_o       = pa_s[PA_W-1:INDEX_WIDTH];
        if (ld_rvalid_i) begin
          state_s = last_s ? S_DONE : S_REQ;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (ld_rvalid_i) begin
          state_s = last_s ? S_DONE : S_REQ;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DONE: begin
        busy_o        = 1'b1;
        done_o        = 1'b1;
        restored_sp_o = addr_r;
        state_s       = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    if (load_done_s) begin
      shadow_reg_we_o    = 1'b1;
      shadow_reg_waddr_o = idx_r;
      shadow_reg_wdata_o = ld_rdata_i;
    end else begin
      shadow_reg_we_o    = 1'b0;
      shadow_reg_waddr_o = {ADDR_WIDTH{1'b0}};
      shadow_reg_wdata_o = {DATA_WIDTH{1'b0}};
    end
  end

  shadow_register_restorer_chk u_chk (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .busy        (busy_o),
    .restore_req (restore_req_i)
  );

endmodule
